// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI transfer sequencer: sequencer state encoding,
// byte width and the default fill byte.
package spi_seq_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] FILL_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Bundle of the sequencer's command, TX/RX FIFO and SPI-master byte ports.
// slave = sequencer side, master = surrounding logic / bench side.
interface spi_xfer_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_tx_en;
  logic             cmd_rx_en;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       m_tx_data;
  logic             m_tx_valid;
  logic             m_tx_ready;
  logic [7:0]       m_rx_data;
  logic             m_rx_valid;
  logic             busy;
  logic             done;
  logic             error;

  modport slave (
    input  cmd_valid, cmd_len, cmd_tx_en, cmd_rx_en, wr_data, wr_valid,
           rd_ready, m_tx_ready, m_rx_data, m_rx_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, m_tx_data, m_tx_valid,
           busy, done, error
  );

  modport master (
    output cmd_valid, cmd_len, cmd_tx_en, cmd_rx_en, wr_data, wr_valid,
           rd_ready, m_tx_ready, m_rx_data, m_rx_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, m_tx_data, m_tx_valid,
           busy, done, error
  );
endinterface

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head:
// out_data is valid whenever out_valid is high.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = BYTE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  head_reg;
  logic          push;
  logic          pop;

  assign in_ready   = (count_reg != CW'(DEPTH));
  assign out_valid  = (count_reg != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign out_data   = head_reg;
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // The next head comes from the RAM if it is already stored there,
      // otherwise straight from the incoming write.
      if (pop) begin
        if (count_reg > CW'(1)) head_reg <= mem[rd_ptr_inc];
        else if (push)          head_reg <= in_data;
      end else if (push && (count_reg == '0)) begin
        head_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Burst-level front end for a byte SPI master: streams TX FIFO or fill bytes
// and collects replies into an RX FIFO. Optional watchdog: SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int                DEPTH          = 8,
  parameter int                LEN_W          = 8,
  parameter logic [BYTE_W-1:0] FILL_BYTE      = FILL_BYTE_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  spi_xfer_sequencer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state_reg;
  logic [LEN_W-1:0]  remaining_reg;
  logic              tx_en_reg;
  logic              rx_en_reg;
  logic              m_tx_valid_reg;
  logic [BYTE_W-1:0] m_tx_data_reg;
  logic              done_reg;

  logic [BYTE_W-1:0] tx_head;
  logic              tx_has;
  logic              tx_pop;
  logic [CW-1:0]     tx_count;
  logic              rx_push;
  logic              rx_in_ready;
  logic [CW-1:0]     rx_count;
  logic              load_go;
  logic              unused_ok;

  spi_seq_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .in_data(bus.wr_data), .in_valid(bus.wr_valid), .in_ready(bus.wr_ready),
    .out_data(tx_head), .out_valid(tx_has), .out_ready(tx_pop),
    .count(tx_count)
  );

  spi_seq_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .in_data(bus.m_rx_data), .in_valid(rx_push), .in_ready(rx_in_ready),
    .out_data(bus.rd_data), .out_valid(bus.rd_valid), .out_ready(bus.rd_ready),
    .count(rx_count)
  );

  assign unused_ok = &{1'b0, tx_count, rx_in_ready};

  // RX space is reserved before issue, so the single in-flight reply can
  // never overflow the RX FIFO.
  assign load_go = (!tx_en_reg || tx_has) && (!rx_en_reg || (rx_count != CW'(DEPTH)));
  assign tx_pop  = (state_reg == LOAD) && load_go && tx_en_reg;
  assign rx_push = (state_reg == WAIT) && bus.m_rx_valid && rx_en_reg;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            error_reg;
  assign bus.error = error_reg;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      tx_en_reg      <= 1'b0;
      rx_en_reg      <= 1'b0;
      m_tx_valid_reg <= 1'b0;
      m_tx_data_reg  <= '0;
      done_reg       <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wd_reg         <= '0;
      error_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      error_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            remaining_reg <= bus.cmd_len;
            tx_en_reg     <= bus.cmd_tx_en;
            rx_en_reg     <= bus.cmd_rx_en;
            if (bus.cmd_len == '0) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_go) begin
            m_tx_data_reg  <= tx_en_reg ? tx_head : FILL_BYTE;
            m_tx_valid_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_tx_ready) begin
            m_tx_valid_reg <= 1'b0;
            state_reg      <= WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            wd_reg         <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.m_rx_valid) begin
            remaining_reg <= remaining_reg - LEN_W'(1);
            if (remaining_reg == LEN_W'(1)) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= LOAD;
            end
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
            remaining_reg <= '0;
            state_reg     <= FINISH;
            done_reg      <= 1'b1;
            error_reg     <= 1'b1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
`endif
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.m_tx_valid = m_tx_valid_reg;
  assign bus.m_tx_data  = m_tx_data_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed self-checking bench for spi_xfer_sequencer; the watchdog scenario
// runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_xfer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.LEN_W(8)) bus ();

  spi_xfer_sequencer #(
    .DEPTH(8), .LEN_W(8), .FILL_BYTE(8'hFF), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int done_count = 0;
  int tx_valid_cycles = 0;
  int error_cycles = 0;

  always @(posedge clk) begin
    if (bus.done)       done_count      <= done_count + 1;
    if (bus.m_tx_valid) tx_valid_cycles <= tx_valid_cycles + 1;
    if (bus.error)      error_cycles    <= error_cycles + 1;
  end

  task automatic cmd(input logic [7:0] len, input logic tx, input logic rx);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_len = len; bus.cmd_tx_en = tx; bus.cmd_rx_en = rx;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("cmd len=%0d tx_en=%0d rx_en=%0d", len, tx, rx);
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_data = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    $display("tx_fifo write %h", d);
  endtask

  task automatic pop_rx(output logic [7:0] d, output logic v);
    @(negedge clk);
    d = bus.rd_data; v = bus.rd_valid;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
    $display("rx_fifo read %h valid=%0d", d, v);
  endtask

  // Acts as the SPI master accepting one byte; returns in the first WAIT cycle.
  task automatic take_byte(output logic [7:0] d, output logic ok);
    ok = 1'b0; d = 8'h00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_tx_valid) begin ok = 1'b1; break; end
    end
    if (ok) begin
      d = bus.m_tx_data;
      bus.m_tx_ready = 1'b1;
      @(negedge clk);
      bus.m_tx_ready = 1'b0;
    end
    $display("master took %h ok=%0d", d, ok);
  endtask

  task automatic return_byte(input logic [7:0] r);
    @(negedge clk);
    bus.m_rx_data = r; bus.m_rx_valid = 1'b1;
    @(negedge clk);
    bus.m_rx_valid = 1'b0;
    $display("master returned %h", r);
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.cmd_valid = 0; bus.cmd_len = 0; bus.cmd_tx_en = 0; bus.cmd_rx_en = 0;
    bus.wr_data = 0; bus.wr_valid = 0; bus.rd_ready = 0;
    bus.m_tx_ready = 0; bus.m_rx_data = 0; bus.m_rx_valid = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.m_tx_valid,
         bus.m_tx_data, bus.busy, bus.done, bus.error} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000})
      $display("FAIL reset_values got=%b", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data,
               bus.m_tx_valid, bus.m_tx_data, bus.busy, bus.done, bus.error});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] b; logic ok; logic v; int d0;
    push_tx(8'hA5); push_tx(8'h3C);
    d0 = done_count;
    cmd(8'd2, 1'b1, 1'b1);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'hA5}) $display("FAIL basic_tx0 got=%h exp=1a5", {ok, b}); else passed++;
    return_byte(8'h5A);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h3C}) $display("FAIL basic_tx1 got=%h exp=13c", {ok, b}); else passed++;
    return_byte(8'hC3);
    wait_done(ok);
    checks++; if ({ok, bus.busy} !== 2'b11) $display("FAIL basic_done_busy got=%b exp=11", {ok, bus.busy}); else passed++;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.cmd_ready, bus.done} !== 3'b010)
      $display("FAIL basic_after_done got=%b exp=010", {bus.busy, bus.cmd_ready, bus.done});
    else passed++;
    checks++; if (done_count - d0 !== 1) $display("FAIL basic_done_pulses got=%0d exp=1", done_count - d0); else passed++;
    pop_rx(b, v);
    checks++; if ({v, b} !== {1'b1, 8'h5A}) $display("FAIL basic_rx0 got=%h exp=15a", {v, b}); else passed++;
    pop_rx(b, v);
    checks++; if ({v, b} !== {1'b1, 8'hC3}) $display("FAIL basic_rx1 got=%h exp=1c3", {v, b}); else passed++;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL basic_rx_empty got=%b exp=0", bus.rd_valid); else passed++;
  endtask

  task automatic test_fill;
    logic [7:0] b; logic ok; logic v;
    push_tx(8'h77);
    cmd(8'd3, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      take_byte(b, ok);
      checks++; if ({ok, b} !== {1'b1, 8'hFF}) $display("FAIL fill_tx%0d got=%h exp=1ff", k, {ok, b}); else passed++;
      return_byte(8'h01 + 8'(k));
    end
    wait_done(ok);
    checks++; if (ok !== 1'b1) $display("FAIL fill_done got=%b exp=1", ok); else passed++;
    cmd(8'd1, 1'b1, 1'b0);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h77}) $display("FAIL fill_tx_untouched got=%h exp=177", {ok, b}); else passed++;
    return_byte(8'hEE);
    wait_done(ok);
    for (int k = 0; k < 3; k++) begin
      pop_rx(b, v);
      checks++;
      if ({v, b} !== {1'b1, 8'h01 + 8'(k)}) $display("FAIL fill_rx%0d got=%h exp=%h", k, {v, b}, {1'b1, 8'h01 + 8'(k)});
      else passed++;
    end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL fill_rx_discard got=%b exp=0", bus.rd_valid); else passed++;
  endtask

  task automatic test_zero_len;
    int d0; int t0;
    @(negedge clk);
    d0 = done_count; t0 = tx_valid_cycles;
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0; bus.cmd_tx_en = 1'b1; bus.cmd_rx_en = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("cmd len=0 tx_en=1 rx_en=1");
    // Accept cycle is cycle 1; done must be up in cycle 2.
    checks++; if ({bus.done, bus.busy} !== 2'b11) $display("FAIL zero_done got=%b exp=11", {bus.done, bus.busy}); else passed++;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001)
      $display("FAIL zero_after got=%b exp=001", {bus.done, bus.busy, bus.cmd_ready});
    else passed++;
    checks++;
    if ({tx_valid_cycles - t0, done_count - d0} !== {32'd0, 32'd1})
      $display("FAIL zero_counts tx_valid=%0d done=%0d exp 0/1", tx_valid_cycles - t0, done_count - d0);
    else passed++;
  endtask

  task automatic test_rx_full_stall;
    logic [7:0] b; logic ok; logic v; logic all_ok; logic stalled;
    logic [7:0] exp_q [8];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21};
    cmd(8'd8, 1'b0, 1'b1);
    all_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      take_byte(b, ok);
      all_ok &= ok && (b == 8'hFF);
      return_byte(8'h10 + 8'(k));
    end
    wait_done(ok);
    checks++; if ({all_ok, ok} !== 2'b11) $display("FAIL full_prefill got=%b exp=11", {all_ok, ok}); else passed++;
    cmd(8'd2, 1'b0, 1'b1);
    stalled = 1'b1;
    repeat (6) begin @(negedge clk); stalled &= !bus.m_tx_valid && bus.busy; end
    checks++; if (stalled !== 1'b1) $display("FAIL full_stall0 got=%b exp=1", stalled); else passed++;
    pop_rx(b, v);
    checks++; if ({v, b} !== {1'b1, 8'h10}) $display("FAIL full_pop0 got=%h exp=110", {v, b}); else passed++;
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'hFF}) $display("FAIL full_release got=%h exp=1ff", {ok, b}); else passed++;
    return_byte(8'h20);
    stalled = 1'b1;
    repeat (4) begin @(negedge clk); stalled &= !bus.m_tx_valid && bus.busy; end
    checks++; if (stalled !== 1'b1) $display("FAIL full_stall1 got=%b exp=1", stalled); else passed++;
    pop_rx(b, v);
    checks++; if ({v, b} !== {1'b1, 8'h11}) $display("FAIL full_pop1 got=%h exp=111", {v, b}); else passed++;
    take_byte(b, ok);
    return_byte(8'h21);
    wait_done(ok);
    checks++; if (ok !== 1'b1) $display("FAIL full_done got=%b exp=1", ok); else passed++;
    for (int k = 0; k < 8; k++) begin
      pop_rx(b, v);
      checks++;
      if ({v, b} !== {1'b1, exp_q[k]}) $display("FAIL full_drain%0d got=%h exp=%h", k, {v, b}, {1'b1, exp_q[k]});
      else passed++;
    end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL full_drained got=%b exp=0", bus.rd_valid); else passed++;
  endtask

  task automatic test_tx_empty_stall;
    logic [7:0] b; logic ok; logic stalled;
    cmd(8'd2, 1'b1, 1'b0);
    stalled = 1'b1;
    repeat (5) begin @(negedge clk); stalled &= !bus.m_tx_valid && bus.busy; end
    checks++; if (stalled !== 1'b1) $display("FAIL txe_stall0 got=%b exp=1", stalled); else passed++;
    push_tx(8'h11);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h11}) $display("FAIL txe_tx0 got=%h exp=111", {ok, b}); else passed++;
    return_byte(8'h00);
    stalled = 1'b1;
    repeat (5) begin @(negedge clk); stalled &= !bus.m_tx_valid && bus.busy; end
    checks++; if (stalled !== 1'b1) $display("FAIL txe_stall1 got=%b exp=1", stalled); else passed++;
    push_tx(8'h22);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h22}) $display("FAIL txe_tx1 got=%h exp=122", {ok, b}); else passed++;
    return_byte(8'h00);
    wait_done(ok);
    checks++; if (ok !== 1'b1) $display("FAIL txe_done got=%b exp=1", ok); else passed++;
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] b; logic ok; logic early;
    cmd(8'd1, 1'b0, 1'b0);
    take_byte(b, ok);
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      early |= bus.done;
      @(negedge clk);
    end
    checks++;
    if ({ok, early, bus.done, bus.error} !== 4'b1011)
      $display("FAIL timeout_pulse got=%b exp=1011", {ok, early, bus.done, bus.error});
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.done, bus.error} !== 3'b100)
      $display("FAIL timeout_idle got=%b exp=100", {bus.cmd_ready, bus.done, bus.error});
    else passed++;
  endtask
`else
  task automatic test_no_error;
    checks++; if (error_cycles !== 0) $display("FAIL error_tied got=%0d exp=0", error_cycles); else passed++;
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] b; logic ok; logic v; int d0; logic stalled;
    push_tx(8'h31); push_tx(8'h32); push_tx(8'h33);
    cmd(8'd2, 1'b1, 1'b1);
    take_byte(b, ok);
    return_byte(8'h41);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h32}) $display("FAIL rstm_tx1 got=%h exp=132", {ok, b}); else passed++;
    d0 = done_count;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.m_tx_valid,
         bus.m_tx_data, bus.busy, bus.done, bus.error} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000})
      $display("FAIL rstm_values got=%b", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data,
               bus.m_tx_valid, bus.m_tx_data, bus.busy, bus.done, bus.error});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_count !== d0) $display("FAIL rstm_no_done got=%0d exp=%0d", done_count, d0); else passed++;
    cmd(8'd1, 1'b1, 1'b1);
    stalled = 1'b1;
    repeat (4) begin @(negedge clk); stalled &= !bus.m_tx_valid; end
    checks++; if (stalled !== 1'b1) $display("FAIL rstm_tx_flushed got=%b exp=1", stalled); else passed++;
    push_tx(8'h42);
    take_byte(b, ok);
    checks++; if ({ok, b} !== {1'b1, 8'h42}) $display("FAIL rstm_tx_new got=%h exp=142", {ok, b}); else passed++;
    return_byte(8'h24);
    wait_done(ok);
    pop_rx(b, v);
    checks++; if ({v, b} !== {1'b1, 8'h24}) $display("FAIL rstm_rx_new got=%h exp=124", {v, b}); else passed++;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL rstm_rx_flushed got=%b exp=0", bus.rd_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_zero_len();
    test_rx_full_stall();
    test_tx_empty_stall();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_error();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- Multi-byte transaction front end that sits directly upstream of the byte-level SPI master.
- Accepts a command of N bytes and streams TX bytes from an internal TX FIFO, or a fill byte, into the master's tx_valid/tx_ready port.
- Collects each returned rx_data byte into an internal RX FIFO.
- Pulses done when the transaction completes, giving software/bus logic a buffered, burst-level SPI interface.

Parameters:
- DEPTH, 8: entries per FIFO (TX and RX); power of 2, minimum 2.
- LEN_W, 8: width of the command byte-count field.
- FILL_BYTE, 8'hFF: byte sent when the command does not source TX data.
- TIMEOUT_CYCLES, 64: clk cycles allowed between byte issue and m_rx_valid; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_len  in  LEN_W  number of bytes in the transaction; 0 is legal.
- cmd_tx_en  in  1  1: bytes popped from TX FIFO; 0: FILL_BYTE sent.
- cmd_rx_en  in  1  1: returned bytes pushed to RX FIFO; 0: discarded.
- wr_data  in  8  TX FIFO write data.
- wr_valid  in  1  TX FIFO write request.
- wr_ready  out  1  TX FIFO not full.
- rd_data  out  8  RX FIFO head.
- rd_valid  out  1  RX FIFO not empty.
- rd_ready  in  1  RX FIFO pop when rd_valid && rd_ready.
- m_tx_data  out  8  byte to SPI master.
- m_tx_valid  out  1  byte request to SPI master.
- m_tx_ready  in  1  SPI master idle/ready.
- m_rx_data  in  8  byte received by SPI master.
- m_rx_valid  in  1  one-cycle pulse from SPI master.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at transaction end.
- error  out  1  one-cycle pulse with done on timeout abort.

Behaviour:
- Reset values: cmd_ready=1, wr_ready=1, rd_valid=0, rd_data=0, m_tx_valid=0, m_tx_data=0, busy=0, done=0, error=0. FIFOs are emptied, remaining count=0, state=IDLE.
- Reset mid-transaction aborts with no done pulse. The master is reset independently.
- States: IDLE, LOAD, ISSUE, WAIT, FINISH.
- IDLE: on command accept, latch cmd_len into remaining and latch tx_en/rx_en.
  - len=0: go to FINISH.
  - Otherwise: go to LOAD.
- LOAD: proceed to ISSUE only when both hold:
  - TX source ready: tx_en=0, or TX FIFO not empty.
  - RX sink ready: rx_en=0, or RX FIFO not full.
  - When proceeding, register m_tx_data (FIFO head popped, or FILL_BYTE) and assert m_tx_valid next cycle.
  - Otherwise stall indefinitely. This space reservation guarantees no RX overflow, since only one byte is ever in flight.
- ISSUE: hold m_tx_valid/m_tx_data stable until m_tx_valid && m_tx_ready, then deassert m_tx_valid on the next edge and go to WAIT.
- WAIT: on m_rx_valid:
  - If rx_en, push m_rx_data.
  - Decrement remaining.
  - remaining was 1: go to FINISH; else go to LOAD.
  - m_rx_valid outside WAIT is ignored.
- FINISH: done=1 for one cycle, then IDLE.
  - Minimum command-accept-to-done latency is 2 cycles for len=0.
  - For len>0 it is 3 cycles plus the master time per byte.
- FIFOs:
  - Write refused when full (wr_ready=0); pop ignored when empty.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - RX pop and sequencer push in the same cycle are legal when full.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- rd_data is registered first-word-fall-through: head is valid whenever rd_valid=1.
- A new command is not accepted until after the done cycle; there are no back-to-back overlaps.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without m_rx_valid, go to FINISH with done=1 and error=1 in the same cycle.
  - The remaining count is discarded; TX FIFO contents are not flushed.
- Without the macro: error is tied 0, there is no counter, and WAIT is unbounded.

Decomposition:
- Package spi_seq_pkg holds:
  - the state encoding constants (IDLE=0 … FINISH=4, 3 bits);
  - the byte width constant (8);
  - the default FILL_BYTE.
- Sub-module spi_seq_fifo: a parameterised synchronous byte FIFO with valid/ready ports and a count output, instantiated twice (TX and RX).

Test Plan:
- Write 8'hA5, 8'h3C to TX; cmd_len=2, tx_en=1, rx_en=1; slave returns 8'h5A, 8'hC3 -> m_tx_data sequence A5, 3C; RX FIFO holds 5A, C3; one done pulse; busy falls the cycle after done.
- cmd_len=3, tx_en=0, rx_en=1 -> three bytes of 8'hFF sent; TX FIFO untouched; three RX entries.
- cmd_len=0 -> done two cycles after accept; m_tx_valid never asserts.
- DEPTH=8, RX FIFO pre-filled by a 8-byte read, then a 2-byte read command -> stalls in LOAD with m_tx_valid=0 until rd_ready pops one entry; final RX count 8, no data lost.
- cmd_len=2, tx_en=1 with TX FIFO empty -> stalls in LOAD; writing 8'h11 mid-stall releases it; the second byte waits for the next write.
- With SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, and m_rx_valid withheld -> done=1 and error=1 exactly 16 WAIT cycles after byte issue; cmd_ready=1 the following cycle.
- Assert rst during WAIT -> all outputs at reset values the same cycle; FIFOs report empty.
